// File: rtl/pool_flatten_stream_pkg.sv
// Stage-3 flatten defaults: pooled map geometry, word width and bank FSM encoding.
// Derived widths are computed here so that the interface, top and bank all agree.
package pool_flatten_stream_pkg;
    localparam int CH     = 3;
    localparam int POOL_H = 4;
    localparam int POOL_W = 4;
    localparam int DW     = 32;
    localparam int P      = POOL_H * POOL_W;
    localparam int NW     = CH * P;
    localparam int IW     = (NW > 1) ? $clog2(NW) : 1;
    localparam int PW     = (P > 1) ? $clog2(P) : 1;
    localparam int CW     = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } bank_st_e;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] index;
        logic          last;
    } flat_word_t;
endpackage

// File: rtl/pool_flatten_stream_if.sv
// Pooling-side beat input plus flattened valid/ready output and status of pool_flatten_stream.
interface pool_flatten_stream_if;
    import pool_flatten_stream_pkg::*;

    logic               i_pool_valid;
    logic [CH*DW-1:0]   i_pool_data;
    logic               o_flat_valid;
    logic               i_flat_ready;
    logic [DW-1:0]      o_flat_data;
    logic [IW-1:0]      o_flat_index;
    logic               o_flat_last;
    logic               o_overflow;
    logic [7:0]         o_frame_cnt;

    modport slave (
        input  i_pool_valid, i_pool_data, i_flat_ready,
        output o_flat_valid, o_flat_data, o_flat_index, o_flat_last, o_overflow, o_frame_cnt
    );

    modport master (
        output i_pool_valid, i_pool_data, i_flat_ready,
        input  o_flat_valid, o_flat_data, o_flat_index, o_flat_last, o_overflow, o_frame_cnt
    );
endinterface

// File: rtl/pool_flatten_stream_flatten_bank.sv
// One frame of storage addressed [c][p]: CH-wide write at pixel p, single-word async read.
module flatten_bank
    import pool_flatten_stream_pkg::*;
(
    input  logic             clk,
    input  logic             we_i,
    input  logic [PW-1:0]    wpix_i,
    input  logic [CH*DW-1:0] wdata_i,
    input  logic [CW-1:0]    rc_i,
    input  logic [PW-1:0]    rp_i,
    output logic [DW-1:0]    rdata_o
);
    // Contents are don't-care after reset, so the array carries no reset.
    logic [DW-1:0] mem_q [CH][P];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int c = 0; c < CH; c++) mem_q[c][wpix_i] <= wdata_i[c*DW +: DW];
        end
    end

    assign rdata_o = mem_q[rc_i][rp_i];
endmodule

// File: rtl/pool_flatten_stream.sv
// Captures one pooled map per frame and replays it channel-major over valid/ready.
// Define FLATTEN_PINGPONG_EN for two banks so filling overlaps draining.
module pool_flatten_stream
    import pool_flatten_stream_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    pool_flatten_stream_if.slave bus
);
`ifdef FLATTEN_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    bank_st_e      st_q [2];
    logic          wr_bank_q, rd_bank_q;
    logic [PW-1:0] wr_pix_q, rd_p_q;
    logic [CW-1:0] rd_c_q;
    logic [IW-1:0] rd_idx_q;
    logic          rd_done_q;
    flat_word_t    out_q;
    logic          vld_q, ovf_q;
    logic [7:0]    frm_q;

    logic [DW-1:0] rdata [2];
    logic [DW-1:0] rd_word;
    logic          accept, frame_done, rd_active, load, can_write, we;

    assign accept     = vld_q && bus.i_flat_ready;
    assign frame_done = accept && out_q.last;
    // rd_done_q marks that the last word sits in the output register awaiting accept
    assign rd_active  = (st_q[rd_bank_q] == S_DRAIN) && !rd_done_q;
    assign load       = rd_active && (!vld_q || bus.i_flat_ready);
`ifdef FLATTEN_PINGPONG_EN
    // A bank released by the final accept can take a beat on that same edge.
    assign can_write  = (st_q[wr_bank_q] == S_FILL) || (frame_done && (wr_bank_q == rd_bank_q));
`else
    assign can_write  = (st_q[wr_bank_q] == S_FILL);
`endif
    assign we         = bus.i_pool_valid && can_write;

    for (genvar b = 0; b < NB; b++) begin : g_bank
        flatten_bank u_bank (
            .clk     (clk),
            .we_i    (we && (wr_bank_q == 1'(b))),
            .wpix_i  (wr_pix_q),
            .wdata_i (bus.i_pool_data),
            .rc_i    (rd_c_q),
            .rp_i    (rd_p_q),
            .rdata_o (rdata[b])
        );
    end
    if (NB == 1) begin : g_tie
        assign rdata[1] = '0;
    end

    assign rd_word = rdata[rd_bank_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q[0]   <= S_FILL;
            st_q[1]   <= S_FILL;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_pix_q  <= '0;
            rd_c_q    <= '0;
            rd_p_q    <= '0;
            rd_idx_q  <= '0;
            rd_done_q <= 1'b0;
            out_q     <= '0;
            vld_q     <= 1'b0;
            ovf_q     <= 1'b0;
            frm_q     <= '0;
        end else begin
            if (bus.i_pool_valid && !can_write) ovf_q <= 1'b1;

            if (load) begin
                vld_q       <= 1'b1;
                out_q.data  <= rd_word;
                out_q.index <= rd_idx_q;
                out_q.last  <= (rd_idx_q == IW'(NW-1));
                if (rd_idx_q == IW'(NW-1)) begin
                    rd_done_q <= 1'b1;
                    rd_idx_q  <= '0;
                    rd_c_q    <= '0;
                    rd_p_q    <= '0;
                end else begin
                    rd_idx_q <= rd_idx_q + 1'b1;
                    if (rd_p_q == PW'(P-1)) begin
                        rd_p_q <= '0;
                        rd_c_q <= rd_c_q + 1'b1;
                    end else begin
                        rd_p_q <= rd_p_q + 1'b1;
                    end
                end
            end else if (accept) begin
                vld_q <= 1'b0;
            end

            if (frame_done) begin
                frm_q           <= frm_q + 1'b1;
                st_q[rd_bank_q] <= S_FILL;
                rd_done_q       <= 1'b0;
                if (NB == 2) rd_bank_q <= ~rd_bank_q;
            end

            // Placed after the release so a same-edge completion wins.
            if (we) begin
                if (wr_pix_q == PW'(P-1)) begin
                    wr_pix_q        <= '0;
                    st_q[wr_bank_q] <= S_DRAIN;
                    if (NB == 2) wr_bank_q <= ~wr_bank_q;
                end else begin
                    wr_pix_q <= wr_pix_q + 1'b1;
                end
            end
        end
    end

    assign bus.o_flat_valid = vld_q;
    assign bus.o_flat_data  = out_q.data;
    assign bus.o_flat_index = out_q.index;
    assign bus.o_flat_last  = out_q.last;
    assign bus.o_overflow   = ovf_q;
    assign bus.o_frame_cnt  = frm_q;
endmodule

// File: tb/tb_pool_flatten_stream.sv
// Scoreboard bench for pool_flatten_stream: frames push expected words, a negedge monitor pops.
module tb_pool_flatten_stream;
    import pool_flatten_stream_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pool_flatten_stream_if bus();
    pool_flatten_stream dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    flat_word_t exp_q[$];
    flat_word_t exp_w, hold_w;
    logic       stall_q = 1'b0;
    int n_chk = 0, n_bad = 0, n_acc = 0, exp_frames = 0;
    int rdy_mode = 0;  // 0 high, 1 random, 2 low

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 64'(bus.o_flat_valid), 64'd0);
        chk({tag, "_data"},  64'(bus.o_flat_data),  64'd0);
        chk({tag, "_index"}, 64'(bus.o_flat_index), 64'd0);
        chk({tag, "_last"},  64'(bus.o_flat_last),  64'd0);
        chk({tag, "_ovf"},   64'(bus.o_overflow),   64'd0);
        chk({tag, "_frame"}, 64'(bus.o_frame_cnt),  64'd0);
    endtask

    // Beat p carries base + c*100 + p on channel c; expected words are queued c-major.
    task automatic send_frame(input int base, input int max_gap, input bit expect_it);
        int gap;
        flat_word_t w;
        for (int p = 0; p < P; p++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            bus.i_pool_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            bus.i_pool_valid = 1'b1;
            for (int c = 0; c < CH; c++) bus.i_pool_data[c*DW +: DW] = DW'(base + c*100 + p);
            @(posedge clk); #1;
        end
        bus.i_pool_valid = 1'b0;
        if (expect_it) begin
            for (int c = 0; c < CH; c++)
                for (int p = 0; p < P; p++) begin
                    w.data  = DW'(base + c*100 + p);
                    w.index = IW'(c*P + p);
                    w.last  = (c*P + p == NW-1);
                    exp_q.push_back(w);
                end
            exp_frames++;
        end
    endtask

    task automatic wait_drained(input string name);
        int cyc = 0;
        while ((exp_q.size() != 0 || bus.o_flat_valid) && cyc < 3000) begin
            @(posedge clk); #1; cyc++;
        end
        if (cyc >= 3000) begin
            n_chk++; n_bad++;
            $display("FAIL %s_timeout: got %0d words pending required 0", name, exp_q.size());
        end
        chk({name, "_frame_cnt"}, 64'(bus.o_frame_cnt), 64'(8'(exp_frames)));
    endtask

    initial begin
        bus.i_flat_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.i_flat_ready = 1'b1;
                1:       bus.i_flat_ready = 1'($urandom_range(0, 1));
                default: bus.i_flat_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares accepted words and holds stalled words stable.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    chk("stall_valid", 64'(bus.o_flat_valid), 64'd1);
                    chk("stall_data",  64'(bus.o_flat_data),  64'(hold_w.data));
                    chk("stall_index", 64'(bus.o_flat_index), 64'(hold_w.index));
                end
                stall_q      = bus.o_flat_valid && !bus.i_flat_ready;
                hold_w.data  = bus.o_flat_data;
                hold_w.index = bus.o_flat_index;
                hold_w.last  = bus.o_flat_last;
                if (bus.o_flat_valid && bus.i_flat_ready) begin
                    n_acc++;
                    if (exp_q.size() == 0) begin
                        n_chk++; n_bad++;
                        $display("FAIL unexpected_word: got index %0d required no output", bus.o_flat_index);
                    end else begin
                        exp_w = exp_q.pop_front();
                        chk("data",  64'(bus.o_flat_data),  64'(exp_w.data));
                        chk("index", 64'(bus.o_flat_index), 64'(exp_w.index));
                        chk("last",  64'(bus.o_flat_last),  64'(exp_w.last));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, cyc;
        bus.i_pool_valid = 1'b0;
        bus.i_pool_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single frame, ready high: latency 2 and 48 back-to-back words.
        rdy_mode = 0;
        send_frame(0, 0, 1);
        chk("lat_k_valid", 64'(bus.o_flat_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_k1_valid", 64'(bus.o_flat_valid), 64'd1);
        chk("lat_k1_index", 64'(bus.o_flat_index), 64'd0);
        a0 = n_acc;
        repeat (NW) @(posedge clk);
        #1;
        chk("no_bubbles", 64'(n_acc - a0), 64'(NW));
        wait_drained("t1");

        // Random ready.
        rdy_mode = 1;
        send_frame(1000, 0, 1);
        wait_drained("t2");

        // Input gaps, negative words.
        rdy_mode = 0;
        send_frame(-5000, 5, 1);
        wait_drained("t3");
        chk("t3_ovf", 64'(bus.o_overflow), 64'd0);

`ifndef FLATTEN_PINGPONG_EN
        // Beats injected mid-drain are dropped and flagged.
        rdy_mode = 1;
        a0 = n_acc;
        send_frame(2000, 0, 1);
        cyc = 0;
        while (n_acc < a0 + 10 && cyc < 500) begin @(posedge clk); #1; cyc++; end
        chk("t4_reach_mid", 64'(n_acc >= a0 + 10), 64'd1);
        chk("t4_ovf_before", 64'(bus.o_overflow), 64'd0);
        bus.i_pool_valid = 1'b1;
        bus.i_pool_data  = {CH*DW{1'b1}};
        repeat (3) @(posedge clk);
        #1;
        bus.i_pool_valid = 1'b0;
        chk("t4_ovf_after", 64'(bus.o_overflow), 64'd1);
        wait_drained("t4");
        send_frame(3000, 2, 1);
        wait_drained("t4_next");
        chk("t4_ovf_sticky", 64'(bus.o_overflow), 64'd1);
`else
        // Back-to-back frames, then three frames against a stalled output.
        rdy_mode = 0;
        send_frame(4000, 0, 1);
        send_frame(5000, 0, 1);
        wait_drained("pp2");
        chk("pp2_ovf", 64'(bus.o_overflow), 64'd0);
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_frame(6000, 0, 1);
        send_frame(7000, 0, 1);
        chk("pp3_ovf_before", 64'(bus.o_overflow), 64'd0);
        send_frame(8000, 0, 0);
        chk("pp3_ovf_after", 64'(bus.o_overflow), 64'd1);
        rdy_mode = 0;
        wait_drained("pp3");
`endif

        // Reset at drain index 20 abandons the frame.
        rdy_mode = 0;
        send_frame(9000, 0, 1);
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
        end while (!(bus.o_flat_valid && bus.o_flat_index == IW'(20)) && cyc < 200);
        chk("t5_reach_20", 64'(cyc < 200), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset("t5_rst");
        exp_q.delete();
        exp_frames = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_idle_valid", 64'(bus.o_flat_valid), 64'd0);
        send_frame(500, 1, 1);
        wait_drained("t5");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/pool_flatten_stream.md
# pool_flatten_stream

Frame buffer and serializer placed directly after the stage-3 max-pooling block. It captures one pooled feature map: one beat per pooled pixel, each beat carrying CH channel values side by side. It then streams the map out one word per cycle in channel-major flatten order (index = c*P + p, where P = POOL_H*POOL_W) over a valid/ready handshake to the fully-connected layer. The pooling side has no backpressure, so this block must absorb bursts and report any data it loses.

## Interface
- CH, 3, channels per input beat (equals CI/CO of the pooling stage)
- POOL_H, 4, pooled map height
- POOL_W, 4, pooled map width
- DW, 32, word width (equals OF_BW); data passes through unmodified, sign preserved
- clk  in  1  clock, rising-edge
- reset_n  in  1  reset, asynchronous, active-low
- i_pool_valid  in  1  input beat strobe, no backpressure
- i_pool_data  in  CH*DW  channel c at bits [c*DW +: DW]
- o_flat_valid  out  1  output word valid
- i_flat_ready  in  1  downstream accepts the word when high together with o_flat_valid
- o_flat_data  out  DW  flattened word
- o_flat_index  out  $clog2(CH*P)  flatten index of o_flat_data
- o_flat_last  out  1  high with index CH*P-1
- o_overflow  out  1  sticky; set when an input beat is dropped
- o_frame_cnt  out  8  frames fully drained, wraps 255→0

## Operation
- Storage: CH*P words, addressed [c][p].
- FSM states are S_FILL and S_DRAIN. Reset state is S_FILL.
- S_FILL:
  - Each i_pool_valid writes channel c to [c][wr_pix]; wr_pix increments.
  - The beat with wr_pix = P-1 writes, clears wr_pix, and moves the FSM to S_DRAIN.
  - Gaps in i_pool_valid are allowed; there is no timeout.
- S_DRAIN:
  - Read counters rd_c (outer) and rd_p (inner) walk the storage. No divider is used.
  - The output register loads [rd_c][rd_p] whenever it is empty, or when it is being accepted in the same cycle.
  - After the word with index CH*P-1 is accepted, o_frame_cnt increments and the FSM returns to S_FILL on the next edge.
- Handshake:
  - o_flat_data, o_flat_index and o_flat_last stay stable while o_flat_valid=1 and i_flat_ready=0.
  - o_flat_valid never drops without an accept.
  - When i_flat_ready is held high, one word transfers per cycle with no bubbles after the first word.
- Dropped beats: any i_pool_valid seen while no bank can accept it is discarded and sets o_overflow. o_overflow clears only on reset.
- Reset values: o_flat_valid=0, o_flat_data=0, o_flat_index=0, o_flat_last=0, o_overflow=0, o_frame_cnt=0. Counters clear to 0.
- Storage contents are don't-care after reset. A reset mid-fill or mid-drain abandons the frame, and nothing is emitted afterwards until a complete new frame has been captured.

## Timing
- The final input beat is sampled at edge k. The FSM is in S_DRAIN after edge k, and index 0 appears with o_flat_valid=1 after edge k+1, giving a fill-to-first-word latency of 2 cycles.
- A full drain takes CH*P cycles when ready is held high. With the default parameters this is 48 cycles, indices 0..47.
- If a beat arrives on the same edge as the last-word accept:
  - Single-bank build: the beat is dropped, because the FSM is still in S_DRAIN at that edge.
  - Ping-pong build: the beat is accepted.

## Configuration
- Macro FLATTEN_PINGPONG_EN.
- Defined:
  - Two storage banks are used. Filling continues into the free bank while the other bank drains, and the banks swap roles at frame completion.
  - Overflow occurs only when a beat arrives while both banks hold undrained frames.
  - The FSM states apply per bank. Drain order follows fill order.
- Undefined:
  - A single bank is used.
  - Every i_pool_valid during S_DRAIN is dropped and sets o_overflow.

## Structure
- CH, DW, POOL_H, POOL_W and P defaults, plus the FSM state encodings, belong in the shared header stage3_defines_cnn_core.vh.
- One sub-module, flatten_bank:
  - Register array of CH*P×DW.
  - One write port of CH words at pixel address p.
  - One single-word combinational read port at (c,p).
  - Instantiated once, or twice when FLATTEN_PINGPONG_EN is defined.

## Test plan
- Single frame, input beat p carries channel c = c*100+p, ready held high → outputs 0..15, 100..115, 200..215 on 48 consecutive cycles; last=1 only on index 47; o_frame_cnt=1.
- Pseudo-random ready pattern → identical sequence; data and index stable during every stall cycle.
- Input valid with random gaps of 0–5 cycles → same output as the gap-free case.
- Single-bank build, 3 beats injected mid-drain → o_overflow=1; the drained data is unchanged. The next full frame is drained correctly.
- FLATTEN_PINGPONG_EN build, two back-to-back frames, ready held high → 96 words in order with o_overflow=0. A third frame injected while ready=0 → o_overflow=1.
- Reset asserted at drain index 20 → all outputs return to their reset values immediately. No words are emitted until a new 16-beat frame is captured, which then drains from index 0.
